// File: rtl/uart_pkg.sv
// Shared UART RX definitions: FSM state encodings, default frame geometry and index-width helper.
package uart_pkg;

  localparam int OVERSAMPLE_DEF = 16;
  localparam int DATA_WIDTH_DEF = 8;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE   = ST_IDLE,
    S_START  = ST_START,
    S_DATA   = ST_DATA,
    S_PARITY = ST_PARITY,
    S_STOP   = ST_STOP,
    S_BREAK  = ST_BREAK
  } state_e;

  // Width of data_index; a 1-bit frame still gets a 1-bit index.
  function automatic int iw_f(input int dw);
    return (dw > 1) ? $clog2(dw) : 1;
  endfunction

endpackage

// File: rtl/uart_rx_bit_sampler_if.sv
// Serial-line inputs and deserializer/status outputs of the RX bit sampler.
// parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_bit_sampler_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) ();

  localparam int IW = iw_f(DATA_WIDTH);

  logic          baud_tick;
  logic          rx_in;
  logic          deserializer_enable;
  logic [IW-1:0] data_index;
  logic          sampled_bit;
  logic          rx_done;
  logic          framing_error;
  logic          rx_busy;
`ifdef UART_RX_PARITY_EN
  logic          parity_error;

  modport master (
    output baud_tick, rx_in,
    input  deserializer_enable, data_index, sampled_bit, rx_done, framing_error, rx_busy, parity_error
  );
  modport slave (
    input  baud_tick, rx_in,
    output deserializer_enable, data_index, sampled_bit, rx_done, framing_error, rx_busy, parity_error
  );
`else
  modport master (
    output baud_tick, rx_in,
    input  deserializer_enable, data_index, sampled_bit, rx_done, framing_error, rx_busy
  );
  modport slave (
    input  baud_tick, rx_in,
    output deserializer_enable, data_index, sampled_bit, rx_done, framing_error, rx_busy
  );
`endif

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the idle-high rx line; resets to 1 so reset never looks like a start bit.
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_bit_sampler.sv
// UART RX start detect + mid-bit sampler feeding the deserializer; all outputs registered (1 UCLK after the sampling tick).
// No backpressure: the serial line cannot stall. Optional parity stage under `UART_RX_PARITY_EN`.
module uart_rx_bit_sampler
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF,
  parameter int PARITY_ODD = 0
) (
  input logic                  UCLK,
  input logic                  reset,
  uart_rx_bit_sampler_if.slave bus
);

  localparam int IW = iw_f(DATA_WIDTH);
  localparam int TW = $clog2(OVERSAMPLE);

  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [IW-1:0] BIT_LAST  = IW'(DATA_WIDTH - 1);

  if (OVERSAMPLE < 4 || (OVERSAMPLE % 2) != 0 || DATA_WIDTH < 1 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_rx_bit_sampler: unsupported parameter set");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk_i (UCLK),
    .rst_i (reset),
    .d_i   (bus.rx_in),
    .q_o   (rx_s)
  );

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [IW-1:0] bit_cnt_q, bit_cnt_d;
  logic          den_q, den_d;
  logic [IW-1:0] data_index_q, data_index_d;
  logic          sampled_bit_q, sampled_bit_d;
  logic          rx_done_q, rx_done_d;
  logic          framing_error_q, framing_error_d;
  logic          rx_busy_q, rx_busy_d;
`ifdef UART_RX_PARITY_EN
  logic          par_q, par_d;
  logic          par_err_pend_q, par_err_pend_d;
  logic          parity_error_q, parity_error_d;
`endif

  logic          tick_wrap;
  logic [TW-1:0] tick_next;

  assign tick_wrap = (tick_cnt_q == TICK_LAST);
  assign tick_next = tick_wrap ? '0 : tick_cnt_q + 1'b1;

  always_comb begin
    state_d         = state_q;
    tick_cnt_d      = tick_cnt_q;
    bit_cnt_d       = bit_cnt_q;
    den_d           = 1'b0;
    data_index_d    = data_index_q;
    sampled_bit_d   = sampled_bit_q;
    rx_done_d       = 1'b0;
    framing_error_d = framing_error_q;
`ifdef UART_RX_PARITY_EN
    par_d           = par_q;
    par_err_pend_d  = par_err_pend_q;
    parity_error_d  = parity_error_q;
`endif

    if (bus.baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s) begin
            state_d    = S_START;
            tick_cnt_d = '0;
          end
        end
        S_START: begin
          tick_cnt_d = tick_next;
          // Start bit confirmed at its centre; from here every bit is a full period away.
          if (tick_cnt_q == TICK_MID) begin
            tick_cnt_d = '0;
            if (!rx_s) begin
              state_d   = S_DATA;
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              par_d     = 1'b0;
`endif
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          tick_cnt_d = tick_next;
          if (tick_wrap) begin
            den_d         = 1'b1;
            data_index_d  = bit_cnt_q;
            sampled_bit_d = rx_s;
`ifdef UART_RX_PARITY_EN
            par_d         = par_q ^ rx_s;
`endif
            if (bit_cnt_q == BIT_LAST) begin
              bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
              state_d   = S_PARITY;
`else
              state_d   = S_STOP;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          tick_cnt_d = tick_next;
          if (tick_wrap) begin
            par_err_pend_d = ((par_q ^ rx_s) != PARITY_ODD[0]);
            state_d        = S_STOP;
          end
        end
`endif
        S_STOP: begin
          tick_cnt_d = tick_next;
          if (tick_wrap) begin
            rx_done_d       = 1'b1;
            framing_error_d = !rx_s;
`ifdef UART_RX_PARITY_EN
            parity_error_d  = par_err_pend_q;
`endif
            state_d         = rx_s ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: begin
          // A line held low must return high before a new start bit can be seen.
          if (rx_s) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d    = S_IDLE;
          tick_cnt_d = '0;
        end
      endcase
    end

    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge UCLK) begin
    if (reset) begin
      state_q         <= S_IDLE;
      tick_cnt_q      <= '0;
      bit_cnt_q       <= '0;
      den_q           <= 1'b0;
      data_index_q    <= '0;
      sampled_bit_q   <= 1'b0;
      rx_done_q       <= 1'b0;
      framing_error_q <= 1'b0;
      rx_busy_q       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q           <= 1'b0;
      par_err_pend_q  <= 1'b0;
      parity_error_q  <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      tick_cnt_q      <= tick_cnt_d;
      bit_cnt_q       <= bit_cnt_d;
      den_q           <= den_d;
      data_index_q    <= data_index_d;
      sampled_bit_q   <= sampled_bit_d;
      rx_done_q       <= rx_done_d;
      framing_error_q <= framing_error_d;
      rx_busy_q       <= rx_busy_d;
`ifdef UART_RX_PARITY_EN
      par_q           <= par_d;
      par_err_pend_q  <= par_err_pend_d;
      parity_error_q  <= parity_error_d;
`endif
    end
  end

  assign bus.deserializer_enable = den_q;
  assign bus.data_index          = data_index_q;
  assign bus.sampled_bit         = sampled_bit_q;
  assign bus.rx_done             = rx_done_q;
  assign bus.framing_error       = framing_error_q;
  assign bus.rx_busy             = rx_busy_q;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_error        = parity_error_q;
`endif

endmodule

// File: tb/tb_uart_rx_bit_sampler.sv
// Directed bench for uart_rx_bit_sampler: OVERSAMPLE=16, baud_tick every 4 UCLK, 64 UCLK per bit.
module tb_uart_rx_bit_sampler;
  import uart_pkg::*;

  localparam int DW      = 8;
  localparam int OS      = 16;
  localparam int BIT_CYC = OS * 4;

  logic UCLK  = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] idx_q[$];
  logic        bit_q[$];
  logic        fe_q[$];
`ifdef UART_RX_PARITY_EN
  logic        pe_q[$];
  logic        par_flip = 1'b0;
`endif

  uart_rx_bit_sampler_if #(.DATA_WIDTH(DW)) bus ();

  uart_rx_bit_sampler #(
    .DATA_WIDTH (DW),
    .OVERSAMPLE (OS),
    .PARITY_ODD (0)
  ) dut (
    .UCLK  (UCLK),
    .reset (reset),
    .bus   (bus)
  );

  always #5 UCLK = ~UCLK;

  initial begin
    bus.baud_tick = 1'b0;
    forever begin
      repeat (3) @(negedge UCLK);
      bus.baud_tick = 1'b1;
      @(negedge UCLK);
      bus.baud_tick = 1'b0;
    end
  end

  // Records every strobe and frame completion seen on the outputs.
  initial begin
    forever begin
      @(negedge UCLK);
      if (bus.deserializer_enable === 1'b1) begin
        idx_q.push_back(32'(bus.data_index));
        bit_q.push_back(bus.sampled_bit);
      end
      if (bus.rx_done === 1'b1) begin
        fe_q.push_back(bus.framing_error);
`ifdef UART_RX_PARITY_EN
        pe_q.push_back(bus.parity_error);
`endif
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge UCLK);
  endtask

  task automatic send_bit(input logic b);
    bus.rx_in = b;
    cycles(BIT_CYC);
  endtask

  // Leaves the line at stop_lvl; caller decides when it returns high.
  task automatic send_frame(input logic [DW-1:0] data, input logic stop_lvl, input int stop_cycles);
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(data[i]);
`ifdef UART_RX_PARITY_EN
    send_bit((^data) ^ par_flip);
`endif
    bus.rx_in = stop_lvl;
    cycles(stop_cycles);
  endtask

  task automatic clear_logs();
    idx_q.delete();
    bit_q.delete();
    fe_q.delete();
`ifdef UART_RX_PARITY_EN
    pe_q.delete();
`endif
  endtask

  task automatic expect_bits(input string tag, input logic [15:0] exp_bits, input int n_str);
    chk({tag, "_strobes"}, idx_q.size(), n_str);
    for (int i = 0; i < n_str && i < idx_q.size(); i++) begin
      chk($sformatf("%s_idx%0d", tag, i), idx_q[i], i % DW);
      chk($sformatf("%s_bit%0d", tag, i), 32'(bit_q[i]), 32'(exp_bits[i]));
    end
  endtask

  function automatic logic fe_at(input int k);
    return (fe_q.size() > k) ? fe_q[k] : 1'bx;
  endfunction

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_den"},  32'(bus.deserializer_enable), 0);
    chk({tag, "_idx"},  32'(bus.data_index), 0);
    chk({tag, "_sbit"}, 32'(bus.sampled_bit), 0);
    chk({tag, "_done"}, 32'(bus.rx_done), 0);
    chk({tag, "_fe"},   32'(bus.framing_error), 0);
    chk({tag, "_busy"}, 32'(bus.rx_busy), 0);
`ifdef UART_RX_PARITY_EN
    chk({tag, "_pe"},   32'(bus.parity_error), 0);
`endif
  endtask

  initial begin
    bus.rx_in = 1'b1;
    reset     = 1'b1;
    cycles(4);
    chk_outputs_zero("rst");
    reset = 1'b0;
    cycles(40);
    chk("idle_busy", 32'(bus.rx_busy), 0);

    // Clean frame 0xA5
    clear_logs();
    send_frame(8'hA5, 1'b1, BIT_CYC);
    bus.rx_in = 1'b1;
    cycles(32);
    expect_bits("t1", 16'h00A5, 8);
    chk("t1_dones", fe_q.size(), 1);
    chk("t1_fe", 32'(fe_at(0)), 0);
    chk("t1_busy", 32'(bus.rx_busy), 0);

    // Start-bit glitch of 4 ticks
    clear_logs();
    bus.rx_in = 1'b0;
    cycles(12);
    chk("t2_busy_mid", 32'(bus.rx_busy), 1);
    cycles(4);
    bus.rx_in = 1'b1;
    cycles(100);
    chk("t2_strobes", idx_q.size(), 0);
    chk("t2_dones", fe_q.size(), 0);
    chk("t2_busy", 32'(bus.rx_busy), 0);

    // 0x3C with a low stop bit and the line held low for 40 ticks
    clear_logs();
    send_frame(8'h3C, 1'b0, 100);
    chk("t3_busy_break", 32'(bus.rx_busy), 1);
    chk("t3_dones", fe_q.size(), 1);
    chk("t3_fe", 32'(fe_at(0)), 1);
    cycles(60);
    chk("t3_strobes_low", idx_q.size(), 8);
    bus.rx_in = 1'b1;
    cycles(BIT_CYC * 12);
    expect_bits("t3", 16'h003C, 8);
    chk("t3_dones_after", fe_q.size(), 1);
    chk("t3_busy_end", 32'(bus.rx_busy), 0);
    chk("t3_fe_hold", 32'(bus.framing_error), 1);

    // Reset in mid-frame after the index-3 strobe, then a clean 0x5A
    clear_logs();
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(8'h5A >> i);
    chk("t4_pre_strobes", idx_q.size(), 4);
    chk("t4_pre_lastidx", (idx_q.size() > 0) ? idx_q[idx_q.size()-1] : 32'hFFFF_FFFF, 3);
    chk("t4_fe_held", 32'(bus.framing_error), 1);
    reset = 1'b1;
    cycles(1);
    chk_outputs_zero("t4_rst");
    bus.rx_in = 1'b1;
    cycles(2);
    reset = 1'b0;
    clear_logs();
    cycles(BIT_CYC);
    chk("t4_no_partial", fe_q.size(), 0);
    send_frame(8'h5A, 1'b1, BIT_CYC);
    bus.rx_in = 1'b1;
    cycles(32);
    expect_bits("t4", 16'h005A, 8);
    chk("t4_dones", fe_q.size(), 1);
    chk("t4_fe", 32'(fe_at(0)), 0);

`ifdef UART_RX_PARITY_EN
    // Even parity: wrong then correct parity bit on 0x07
    clear_logs();
    par_flip = 1'b1;
    send_frame(8'h07, 1'b1, BIT_CYC);
    bus.rx_in = 1'b1;
    cycles(32);
    chk("t5_pe_bad", (pe_q.size() > 0) ? 32'(pe_q[0]) : 32'hFFFF_FFFF, 1);
    chk("t5_pe_hold", 32'(bus.parity_error), 1);
    par_flip = 1'b0;
    send_frame(8'h07, 1'b1, BIT_CYC);
    bus.rx_in = 1'b1;
    cycles(32);
    chk("t5_pe_good", (pe_q.size() > 1) ? 32'(pe_q[1]) : 32'hFFFF_FFFF, 0);
    chk("t5_pe_out", 32'(bus.parity_error), 0);
    expect_bits("t5", 16'h0707, 16);
`endif

    // Back-to-back 0xFF then 0x00
    clear_logs();
    send_frame(8'hFF, 1'b1, BIT_CYC);
    send_frame(8'h00, 1'b1, BIT_CYC);
    bus.rx_in = 1'b1;
    cycles(32);
    expect_bits("t6", 16'h00FF, 16);
    chk("t6_dones", fe_q.size(), 2);
    chk("t6_fe0", 32'(fe_at(0)), 0);
    chk("t6_fe1", 32'(fe_at(1)), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
